// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and operand bundle between register read, issue stage and ALU
interface alu_issue_if #(parameter int bit_size = 32);
  logic in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [31:0] instr;
  logic [bit_size-1:0] rs_data, rt_data, src1, src2;
  logic [3:0] ALUOp;
  logic [4:0] shamt, wr_reg;
  logic [7:0] illegal_cnt;
  modport master (
    output in_valid, instr, rs_data, rt_data, flush, out_ready,
    input in_ready, out_valid, ALUOp, src1, src2, shamt, wr_reg, illegal, illegal_cnt
  );
  modport slave (
    input in_valid, instr, rs_data, rt_data, flush, out_ready,
    output in_ready, out_valid, ALUOp, src1, src2, shamt, wr_reg, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: MIPS decode and registered ID/EX operand slot with valid/ready handshake and flush
module alu_issue_stage #(parameter int bit_size = 32) (
  input logic clk,
  input logic rst,
  alu_issue_if.slave bus
);
  logic [5:0] opc, fn;
  logic [bit_size-1:0] sext, zext, d_s1, d_s2;
  logic [3:0] d_op;
  logic [4:0] d_sh, d_wr;
  logic d_ill, accept;
  assign opc = bus.instr[31:26];
  assign fn = bus.instr[5:0];
  assign sext = {{(bit_size-16){bus.instr[15]}}, bus.instr[15:0]};
  assign zext = {{(bit_size-16){1'b0}}, bus.instr[15:0]};
  assign bus.in_ready = !bus.flush && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    d_op = '0;
    d_s1 = bus.rs_data;
    d_s2 = '0;
    d_sh = '0;
    d_wr = '0;
    d_ill = 1'b0;
    if (opc == 6'h00) begin
      d_s2 = bus.rt_data;
      d_sh = bus.instr[10:6];
      d_wr = bus.instr[15:11];
      case (fn)
        6'h20, 6'h21: d_op = 4'd1;
        6'h22, 6'h23: d_op = 4'd2;
        6'h24: d_op = 4'd3;
        6'h25: d_op = 4'd4;
        6'h26: d_op = 4'd5;
        6'h27: d_op = 4'd6;
        6'h2A: d_op = 4'd7;
        6'h00: d_op = 4'd8;
        6'h02: d_op = 4'd9;
        6'h08: d_wr = '0;
        default: d_ill = 1'b1;
      endcase
    end else begin
      d_wr = bus.instr[20:16];
      case (opc)
        6'h08, 6'h09, 6'h23: begin d_op = 4'd1; d_s2 = sext; end
        6'h2B: begin d_op = 4'd1; d_s2 = sext; d_wr = '0; end
        6'h0C: begin d_op = 4'd3; d_s2 = zext; end
        6'h0D: begin d_op = 4'd4; d_s2 = zext; end
        6'h0E: begin d_op = 4'd5; d_s2 = zext; end
        6'h0A: begin d_op = 4'd7; d_s2 = sext; end
        6'h04, 6'h05: begin d_op = opc[0] ? 4'd11 : 4'd10; d_s2 = bus.rt_data; d_wr = '0; end
        default: d_ill = 1'b1;
      endcase
    end
    if (d_ill) begin
      d_op = '0;
      d_s1 = '0;
      d_s2 = '0;
      d_sh = '0;
      d_wr = '0;
    end
  end
  // data fields only load on acceptance so they hold while stalled or drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.ALUOp <= '0;
      bus.src1 <= '0;
      bus.src2 <= '0;
      bus.shamt <= '0;
      bus.wr_reg <= '0;
      bus.illegal <= 1'b0;
      bus.illegal_cnt <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.ALUOp <= d_op;
      bus.src1 <= d_s1;
      bus.src2 <= d_s2;
      bus.shamt <= d_sh;
      bus.wr_reg <= d_wr;
      bus.illegal <= d_ill;
      if (d_ill && bus.illegal_cnt != 8'hFF) bus.illegal_cnt <= bus.illegal_cnt + 8'd1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scoreboard bench for the issue stage handshake and decode
module tb_alu_issue_stage;
  typedef struct {
    logic [3:0] op;
    logic [31:0] s1, s2;
    logic [4:0] sh, wr;
    logic ill;
  } bundle_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  bundle_t q[$];
  bundle_t held;
  logic mv;
  int mc;
  alu_issue_if #(.bit_size(32)) b();
  alu_issue_stage #(.bit_size(32)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  function automatic bundle_t bd(input logic [3:0] op, input logic [31:0] s1, s2, input logic [4:0] sh, wr, input logic ill);
    bundle_t r;
    r.op = op; r.s1 = s1; r.s2 = s2; r.sh = sh; r.wr = wr; r.ill = ill;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_bundle(input string tag, input bundle_t e);
    chk({tag, ".ALUOp"}, b.ALUOp, e.op);
    chk({tag, ".src1"}, b.src1, e.s1);
    chk({tag, ".src2"}, b.src2, e.s2);
    chk({tag, ".shamt"}, b.shamt, e.sh);
    chk({tag, ".wr_reg"}, b.wr_reg, e.wr);
    chk({tag, ".illegal"}, b.illegal, e.ill);
    chk({tag, ".illegal_cnt"}, b.illegal_cnt, mc);
  endtask
  task automatic cyc(input string tag, input logic v, input logic [31:0] i, rs, rt,
                     input logic fl, ordy, input bundle_t e);
    logic acc, nv;
    @(negedge clk);
    b.in_valid = v; b.instr = i; b.rs_data = rs; b.rt_data = rt; b.flush = fl; b.out_ready = ordy;
    #1;
    chk({tag, ".in_ready"}, b.in_ready, !fl && (!mv || ordy));
    acc = v && !fl && (!mv || ordy);
    if (acc) q.push_back(e);
    if (acc && e.ill && mc < 255) mc++;
    nv = fl ? 1'b0 : acc ? 1'b1 : ordy ? 1'b0 : mv;
    @(posedge clk);
    #1;
    mv = nv;
    if (acc) held = q.pop_front();
    chk({tag, ".out_valid"}, b.out_valid, mv);
    chk_bundle(tag, held);
  endtask
  initial begin
    bundle_t z, nb;
    z = bd(0, 0, 0, 0, 0, 0);
    nb = z;
    held = z;
    mv = 1'b0;
    mc = 0;
    b.in_valid = 1'b1; b.instr = 32'h00221820; b.rs_data = 5; b.rt_data = 7;
    b.flush = 1'b0; b.out_ready = 1'b1;
    #12;
    chk("rst.out_valid", b.out_valid, 0);
    chk_bundle("rst", z);
    @(negedge clk);
    rst = 1'b1;
    b.in_valid = 1'b0;
    #1;
    chk("rst.in_ready", b.in_ready, 1);
    cyc("add", 1, 32'h00221820, 5, 7, 0, 1, bd(1, 5, 7, 0, 3, 0));
    cyc("addi", 1, 32'h2022FFFC, 10, 0, 0, 1, bd(1, 10, 32'hFFFFFFFC, 0, 2, 0));
    cyc("ori", 1, 32'h3422FFFF, 1, 0, 0, 1, bd(4, 1, 32'h0000FFFF, 0, 2, 0));
    cyc("sub", 1, 32'h00221822, 5, 7, 0, 1, bd(2, 5, 7, 0, 3, 0));
    cyc("sll", 1, 32'h00021900, 9, 8, 0, 1, bd(8, 9, 8, 4, 3, 0));
    cyc("srl", 1, 32'h00021902, 9, 8, 0, 1, bd(9, 9, 8, 4, 3, 0));
    cyc("slt", 1, 32'h0022182A, 3, 4, 0, 1, bd(7, 3, 4, 0, 3, 0));
    cyc("and", 1, 32'h00221824, 3, 4, 0, 1, bd(3, 3, 4, 0, 3, 0));
    cyc("or", 1, 32'h00221825, 3, 4, 0, 1, bd(4, 3, 4, 0, 3, 0));
    cyc("xor", 1, 32'h00221826, 3, 4, 0, 1, bd(5, 3, 4, 0, 3, 0));
    cyc("nor", 1, 32'h00221827, 3, 4, 0, 1, bd(6, 3, 4, 0, 3, 0));
    cyc("jr", 1, 32'h03E00008, 32'h100, 6, 0, 1, bd(0, 32'h100, 6, 0, 0, 0));
    cyc("lw", 1, 32'h8C220008, 40, 6, 0, 1, bd(1, 40, 8, 0, 2, 0));
    cyc("sw", 1, 32'hAC22FFF8, 40, 6, 0, 1, bd(1, 40, 32'hFFFFFFF8, 0, 0, 0));
    cyc("slti", 1, 32'h2822FFFF, 2, 6, 0, 1, bd(7, 2, 32'hFFFFFFFF, 0, 2, 0));
    cyc("andi", 1, 32'h3022F0F0, 2, 6, 0, 1, bd(3, 2, 32'h0000F0F0, 0, 2, 0));
    cyc("xori", 1, 32'h38228000, 2, 6, 0, 1, bd(5, 2, 32'h00008000, 0, 2, 0));
    cyc("bne", 1, 32'h14220003, 11, 12, 0, 1, bd(11, 11, 12, 0, 0, 0));
    cyc("nop", 1, 32'h00000000, 13, 14, 0, 1, bd(8, 13, 14, 0, 0, 0));
    cyc("badfn", 1, 32'h00221801, 13, 14, 0, 1, bd(0, 0, 0, 0, 0, 1));
    cyc("beq", 1, 32'h10220003, 21, 22, 0, 1, bd(10, 21, 22, 0, 0, 0));
    for (int k = 0; k < 3; k++) cyc("stall", 1, 32'h00221820, 5, 7, 0, 0, bd(1, 5, 7, 0, 3, 0));
    cyc("resume", 1, 32'h00221820, 5, 7, 0, 1, bd(1, 5, 7, 0, 3, 0));
    cyc("drain", 0, 32'h0, 0, 0, 0, 1, nb);
    cyc("idle", 0, 32'h0, 0, 0, 0, 0, nb);
    cyc("fill", 1, 32'h2022FFFC, 10, 0, 0, 0, bd(1, 10, 32'hFFFFFFFC, 0, 2, 0));
    cyc("flush", 1, 32'hFC000000, 1, 2, 1, 1, bd(0, 0, 0, 0, 0, 1));
    cyc("postflush", 1, 32'h3422FFFF, 1, 0, 0, 0, bd(4, 1, 32'h0000FFFF, 0, 2, 0));
    for (int k = 0; k < 260; k++) cyc("illegal", 1, 32'hFC000000, k, k, 0, 1, bd(0, 0, 0, 0, 0, 1));
    chk("sat", b.illegal_cnt, 255);
    @(negedge clk);
    b.in_valid = 1'b1; b.instr = 32'h00221820; b.rs_data = 5; b.rt_data = 7; b.out_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst.out_valid", b.out_valid, 0);
    chk("midrst.illegal_cnt", b.illegal_cnt, 0);
    held = z;
    mv = 1'b0;
    mc = 0;
    q.delete();
    @(posedge clk);
    #1;
    chk_bundle("midrst", z);
    @(negedge clk);
    rst = 1'b1;
    b.in_valid = 1'b0;
    cyc("after_rst", 0, 32'h0, 0, 0, 0, 1, nb);
    cyc("add2", 1, 32'h00221820, 5, 7, 0, 1, bd(1, 5, 7, 0, 3, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that produces the operand and operation bundle consumed by the 32-bit ALU: ALUOp code, src1, src2 and shamt. It decodes a MIPS instruction word, selects and extends operands, and holds the bundle in a registered ID/EX slot with a valid/ready handshake and flush. It sits between the register-file read and the ALU in the pipeline.

## Interface
- bit_size, 32, datapath width of src1/src2/rs_data/rt_data
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  instruction and register data valid this cycle
- in_ready  output  1  stage accepts input this cycle
- instr  input  32  instruction word
- rs_data  input  bit_size  register-file value of rs
- rt_data  input  bit_size  register-file value of rt
- flush  input  1  kill the held bundle and any incoming transfer
- out_valid  output  1  bundle valid for the ALU
- out_ready  input  1  downstream consumes the bundle this cycle
- ALUOp  output  4  ALU operation code
- src1  output  bit_size  first ALU operand
- src2  output  bit_size  second ALU operand
- shamt  output  5  shift amount
- wr_reg  output  5  destination register index; 0 when none
- illegal  output  1  held bundle came from an unsupported instruction
- illegal_cnt  output  8  saturating count of accepted unsupported instructions

## Operation
- ALUOp codes: 0 none, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor, 7 slt, 8 sll, 9 srl, 10 beq, 11 bne.
- R-type (opcode 0x00), by funct: 0x20/0x21 →1; 0x22/0x23 →2; 0x24 →3; 0x25 →4; 0x26 →5; 0x27 →6; 0x2A →7; 0x00 →8; 0x02 →9; 0x08 (jr) →0 with wr_reg 0. src2=rt_data, shamt=instr[10:6], wr_reg=instr[15:11].
- I-type: 0x08/0x09 addi(u) →1, sign-ext; 0x0C andi →3, 0x0D ori →4, 0x0E xori →5, zero-ext; 0x0A slti →7, sign-ext; 0x23 lw →1, sign-ext; 0x2B sw →1, sign-ext, wr_reg 0; 0x04 beq →10, 0x05 bne →11, src2=rt_data, wr_reg 0. Other I-types: wr_reg=instr[20:16], shamt 0.
- src1=rs_data always. Sign-ext replicates instr[15] to bit_size; zero-ext pads zeros.
- Any other opcode/funct: ALUOp 0, src1/src2/shamt/wr_reg 0, illegal 1; illegal_cnt increments on acceptance, saturates at 255.
- instr 0x00000000 decodes as sll $0,$0,0 (ALUOp 8, wr_reg 0); not illegal.

## Timing
- Reset: out_valid 0, ALUOp 0, src1 0, src2 0, shamt 0, wr_reg 0, illegal 0, illegal_cnt 0; takes effect immediately, independent of clk.
- in_ready = !flush && (!out_valid || out_ready), combinational.
- Transfer in when in_valid && in_ready; bundle appears on outputs with out_valid=1 on the next rising edge (1-cycle latency).
- Bundle outputs are stable while out_valid && !out_ready.
- out_valid && out_ready with no new input: out_valid → 0 next edge; data fields hold their last values.
- Simultaneous consume and accept: new bundle replaces old with out_valid staying 1; full throughput, one per cycle.
- flush: out_valid → 0 next edge, incoming instruction dropped, illegal_cnt unchanged for the dropped instruction; flush and out_ready together is still a flush.
- Reset asserted mid-transfer: everything returns to reset values; no partial bundle after release.

## Test plan
- Reset: rst=0 with in_valid=1 → all outputs 0, in_ready=1 after release.
- add $3,$1,$2 (0x00221820), rs_data=5, rt_data=7 → next cycle ALUOp=1, src1=5, src2=7, wr_reg=3, out_valid=1.
- addi $2,$1,-4 (0x2022FFFC) → ALUOp=1, src2=0xFFFFFFFC; ori $2,$1,0xFFFF (0x3422FFFF) → ALUOp=4, src2=0x0000FFFF.
- Backpressure: out_ready=0 for 3 cycles after beq (0x10220003) → in_ready=0, bundle held with ALUOp=10, wr_reg=0; then out_ready=1 → next instruction accepted same cycle.
- flush with out_valid=1 and in_valid=1 → out_valid=0 next edge, incoming dropped.
- 260 back-to-back illegal opcodes (0xFC000000) → illegal=1 each, ALUOp=0, illegal_cnt saturates at 255.
